// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback path.
package rf_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_t;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; a grant implies a transfer, so the
// last-grant register follows the grant directly.
module rr_arbiter2
  import rf_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_alu,
  input  logic req_mem,
  output logic gnt_alu,
  output logic gnt_mem
);

  wb_src_t last_q, last_d;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    if (!rst) begin
      if (req_alu && req_mem) begin
        gnt_mem = (last_q == WB_ALU);
        gnt_alu = (last_q == WB_MEM);
      end else begin
        gnt_alu = req_alu;
        gnt_mem = req_mem;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_alu) begin
      last_d = WB_ALU;
    end else if (gnt_mem) begin
      last_d = WB_MEM;
    end
  end

  // NOTE: reset is synchronous here, so it lives inside the clocked block and
  // the sensitivity list holds only the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= WB_ALU;
    end else begin
      last_q <= last_d;
    end
  end

  a_grant_onehot0 : assert property (@(posedge clk) !(gnt_alu && gnt_mem));

endmodule

// File: rtl/rf_writeback_scheduler.sv
// Arbitrates ALU/MEM writebacks onto the single register-file write port and
// tracks pending destination registers for issue/decode stall decisions.
module rf_writeback_scheduler
  import rf_pkg::*;
(
  input  logic                clk,
  input  logic                rst,

  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rd,
  output logic                issue_ready,

  input  logic [ADDR_W-1:0]   rs1_addr,
  input  logic [ADDR_W-1:0]   rs2_addr,
  output logic                rs_stall,

  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,

  input  logic                mem_valid,
  input  logic [ADDR_W-1:0]   mem_rd,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ready,

  output logic                reg_write,
  output logic [ADDR_W-1:0]   write_reg,
  output logic [DATA_W-1:0]   write_data,

  output logic [NUM_REGS-1:0] pending
);

  logic gnt_alu;
  logic gnt_mem;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_alu (alu_valid),
    .req_mem (mem_valid),
    .gnt_alu (gnt_alu),
    .gnt_mem (gnt_mem)
  );

  assign alu_ready = gnt_alu;
  assign mem_ready = gnt_mem;

  logic                wb_fire;
  wb_req_t             wb_sel;
  logic                issue_fire;

  logic                reg_write_q,  reg_write_d;
  logic [ADDR_W-1:0]   write_reg_q,  write_reg_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic [NUM_REGS-1:0] pending_q,    pending_d;

  // x0 is never pending, so it neither blocks issue nor stalls a reader.
  always_comb begin
    issue_ready = (issue_rd == REG_ZERO) || !pending_q[issue_rd];
    rs_stall    = ((rs1_addr != REG_ZERO) && pending_q[rs1_addr]) ||
                  ((rs2_addr != REG_ZERO) && pending_q[rs2_addr]);
    issue_fire  = issue_valid && issue_ready && (issue_rd != REG_ZERO);
  end

  always_comb begin
    wb_fire = gnt_alu || gnt_mem;
    wb_sel  = gnt_mem ? '{rd: mem_rd, data: mem_data}
                      : '{rd: alu_rd, data: alu_data};
  end

  // Write index/data hold when idle; a write to x0 is accepted but never enabled.
  always_comb begin
    reg_write_d  = wb_fire && (wb_sel.rd != REG_ZERO);
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (wb_fire) begin
      write_reg_d  = wb_sel.rd;
      write_data_d = wb_sel.data;
    end
  end

  // Clear on commit first, then set, so a same-edge re-issue keeps its bit.
  always_comb begin
    pending_d = pending_q;
    if (reg_write_q) begin
      pending_d = pending_d & ~reg_onehot(write_reg_q);
    end
    if (issue_fire) begin
      pending_d = pending_d | reg_onehot(issue_rd);
    end
    pending_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      pending_q    <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      pending_q    <= pending_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign pending    = pending_q;

  a_x0_never_pending : assert property (@(posedge clk) !pending_q[0]);
  a_no_x0_write      : assert property (@(posedge clk) !(reg_write_q && write_reg_q == REG_ZERO));

endmodule
